flit_in_buffer: RTL

FLIT_IN_BUFFER -- requirements
Module: flit_in_buffer

---
 rtl/noc_pkg.sv | 11 +
 rtl/flit_fifo_mem.sv | 28 ++
 rtl/flit_in_buffer.sv | 112 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, default buffer depth, flit type.
// No ports; imported by the NoC building blocks.
// Latency/backpressure: not applicable (definitions only).
package noc_pkg;

  localparam int NOC_DATA_WIDTH = 17;
  localparam int NOC_DEPTH      = 4;

  typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/flit_fifo_mem.sv
// Flit storage array: one synchronous write port, one asynchronous read port, no reset.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_dat write port; i_rd_addr -> o_rd_dat combinational read.
// Latency: write visible on the read port the cycle after the write edge; no backpressure.
module flit_fifo_mem
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = NOC_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]    i_wr_dat,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]    o_rd_dat
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/flit_in_buffer.sv
// Input flit FIFO feeding a downstream register stage; head flit offered with a receive_o load strobe.
// Ports: clk/rst (sync, active-high); in_valid_i/in_data_i/in_ready_o upstream; reg_valid_i/reg_send_i
//   downstream status; receive_o/data_o to the register stage; count_o/full_o/empty_o occupancy.
// Latency 1 cycle (no empty bypass); in_ready_o = !full from registered state only, a full buffer
//   refuses pushes even when popping that cycle.
// Optional macro FLIT_IN_BUFFER_STATS_EN adds hwm_o (peak occupancy) and flit_cnt_o (saturating pop count).
module flit_in_buffer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = NOC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  output logic                     in_ready_o,
  input  logic                     reg_valid_i,
  input  logic                     reg_send_i,
  output logic                     receive_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic [$clog2(DEPTH):0]   count_o,
`ifdef FLIT_IN_BUFFER_STATS_EN
  output logic [$clog2(DEPTH):0]   hwm_o,
  output logic [15:0]              flit_cnt_o,
`endif
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head_dat;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // The register stage can take a flit when it is empty or is emptying this cycle.
  assign w_pop  = ~w_empty & (~reg_valid_i | reg_send_i);
  // Push is gated by registered fullness only, so a simultaneous pop does not open a slot.
  assign w_push = in_valid_i & ~w_full;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers are AW bits wide; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  flit_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push & ~rst),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  (in_data_i),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_head_dat)
  );

  assign in_ready_o = ~w_full;
  assign receive_o  = w_pop;
  // Stale array contents are never exposed while empty.
  assign data_o     = w_empty ? '0 : w_head_dat;
  assign count_o    = r_count;
  assign full_o     = w_full;
  assign empty_o    = w_empty;

`ifdef FLIT_IN_BUFFER_STATS_EN
  logic [CW-1:0] r_hwm;
  logic [15:0]   r_flit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hwm      <= '0;
      r_flit_cnt <= '0;
    end else begin
      if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
      if (w_pop && (r_flit_cnt != 16'hFFFF)) r_flit_cnt <= r_flit_cnt + 16'd1;
    end
  end

  assign hwm_o      = r_hwm;
  assign flit_cnt_o = r_flit_cnt;
`endif

endmodule
